video_timing_gen: RTL
=====================

Name: video_timing_gen

Overview:
Parametrised raster timing generator with internal horizontal and vertical counters. Produces data-enable, blanking, sync and line/frame-start strobes for any video mode. Every output is delayed by a configurable pipeline depth so it lines up with downstream pixel-fetch latency. Sits at the head of the video path, driving the pixel fetch/palette pipeline and the TMDS/DVI encoder.

Parameters:
H_ACTIVE, 1024, visible pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 136, horizontal sync width (pixels)
H_BP, 160, horizontal back porch (pixels)
V_ACTIVE, 768, visible lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 29, vertical back porch (lines)
HS_POL, 0, hsync asserted level (0 = active-low)
VS_POL, 0, vsync asserted level (0 = active-low)
DELAY, 8, output pipeline depth in enabled cycles (>=1)
CNT_W, 12, counter width; H_TOTAL and V_TOTAL must be <= 2^CNT_W

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
en  in  1  clock enable; counters and pipeline advance only when 1
resync  in  1  genlock restart; forces counters to h=0, v=0
de  out  1  active video (h<H_ACTIVE and v<V_ACTIVE)
hblank  out  1  1 when h>=H_ACTIVE
vblank  out  1  1 when v>=V_ACTIVE
hsync  out  1  horizontal sync, level set by HS_POL
vsync  out  1  vertical sync, level set by VS_POL
line_start  out  1  one-cycle strobe for h==0
frame_start  out  1  one-cycle strobe for h==0 and v==0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Defaults give 1344 x 806.
- h counts 0..H_TOTAL-1 and wraps to 0. v increments when h wraps, counts 0..V_TOTAL-1 and wraps to 0.
- hsync asserted for H_ACTIVE+H_FP <= h <= H_ACTIVE+H_FP+H_SYNC-1. vsync asserted for V_ACTIVE+V_FP <= v <= V_ACTIVE+V_FP+V_SYNC-1, whole lines, with edges aligned to h==0.
- Raw flags are decoded combinationally from (h,v) and shifted through a DELAY-stage register chain. Outputs are the last stage. With en held at 1, an output at cycle t reflects the counter state at cycle t-DELAY.
- en=0: counters and every pipeline stage hold, so outputs are frozen. Strobes also hold, so a strobe stretches for the duration of the stall.
- resync=1 on an edge: the counters load h=0, v=0. The in-flight pipeline is not flushed. resync overrides en: counters load 0 even when en=0, and the pipeline does not shift.
- resync while already at h=0, v=0: no visible effect.
- rst=1 (sync, highest priority):
  - counters go to 0;
  - every pipeline stage loads idle values: de=0, hblank=1, vblank=1, hsync=~HS_POL, vsync=~VS_POL, line_start=0, frame_start=0;
  - outputs show those idle values on the cycle after the reset edge;
  - reset mid-frame discards all state.
- After rst deasserts with en=1, the first frame_start appears at the outputs exactly DELAY cycles after the first enabled edge.
- Counter arithmetic is unsigned CNT_W. Totals beyond 2^CNT_W are a configuration error and are flagged by a simulation-only elaboration check.

Optional Feature:
Macro VTG_XY_OUT_EN.
- When defined: adds outputs pix_x [CNT_W-1:0] and pix_y [CNT_W-1:0], the h/v counter values carried through the same DELAY pipeline so they are cycle-aligned with de. Their reset value is 0, and they follow the same en and resync rules as the other outputs.
- When undefined: the ports and the extra pipeline registers are absent.

Test Plan:
1. Small mode: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1, DELAY=1, en=1. Required: line period 14 clocks, frame 112 clocks; hsync low for h=10..12; vsync low for v=5..6; de high for 32 clocks per frame.
2. Reset and latency, DELAY=4. Assert rst for 3 cycles, then release with en=1. Required: idle values during reset; frame_start high on exactly the 4th cycle after release, then every 112 cycles.
3. Stall: toggle en low for 5 cycles mid-line at h=3. Required: all outputs frozen for 5 cycles; the line completes 5 cycles late; de total per line still 8.
4. Genlock: assert resync at h=6, v=2. Required: line_start and frame_start appear DELAY cycles later; the next frame_start follows 112 enabled cycles after that.
5. Priority: rst, resync and en=0 asserted together. Required: reset values win. Then resync with en=0 loads counters to 0 and the outputs stay frozen.
6. With VTG_XY_OUT_EN defined, default 1024x768 mode, DELAY=8. Required: pix_x=1023 and pix_y=767 on the last de cycle of the frame; de drops on the next cycle, when pix_x=1024.

Source files
------------

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//   Parametrised raster timing generator. Free-running horizontal (h) and
//   vertical (v) counters are decoded into raw timing flags. The flags pass
//   through a DELAY-stage register chain, so every output lines up with the
//   downstream pixel-fetch latency.
//
// Ports
//   clk          pixel clock
//   rst          synchronous reset, active-high, highest priority
//   en           clock enable; counters and pipeline advance only when 1
//   resync       genlock restart; loads h=0, v=0 (pipeline is not flushed)
//   de           active video
//   hblank       horizontal blanking (h >= H_ACTIVE)
//   vblank       vertical blanking (v >= V_ACTIVE)
//   hsync        horizontal sync, asserted level HS_POL
//   vsync        vertical sync, asserted level VS_POL
//   line_start   strobe for h == 0
//   frame_start  strobe for h == 0 and v == 0
//   pix_x/pix_y  h/v carried through the same pipeline (VTG_XY_OUT_EN only)
//
// Configuration macro
//   VTG_XY_OUT_EN  when defined, adds the pix_x / pix_y outputs.
// ---------------------------------------------------------------------------
module video_timing_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int DELAY    = 8,
    parameter int CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             resync,
    output logic             de,
    output logic             hblank,
    output logic             vblank,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start
`ifdef VTG_XY_OUT_EN
    ,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // All decode thresholds are strictly below the totals, so they fit CNT_W.
    localparam logic [CNT_W-1:0] H_ACT_C   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_C   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

`ifndef SYNTHESIS
    localparam longint CNT_RANGE = 64'd1 << CNT_W;
    if (longint'(H_TOTAL) > CNT_RANGE || longint'(V_TOTAL) > CNT_RANGE) begin : g_bad_total
        $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 2**CNT_W");
    end
    if (DELAY < 1) begin : g_bad_delay
        $error("video_timing_gen: DELAY must be >= 1");
    end
`endif

    typedef struct packed {
        logic             de;
        logic             hblank;
        logic             vblank;
        logic             hsync;
        logic             vsync;
        logic             line_start;
        logic             frame_start;
`ifdef VTG_XY_OUT_EN
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
`endif
    } stage_t;

    localparam stage_t IDLE = '{
        default: '0,
        hblank:  1'b1,
        vblank:  1'b1,
        hsync:   ~HS_ON,
        vsync:   ~VS_ON
    };

    logic [CNT_W-1:0] h, v;
    logic [CNT_W-1:0] h_next, v_next;
    stage_t           raw;
    stage_t           pipe [DELAY];

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        h_next = h + 1'b1;
        v_next = v;
        if (h == H_LAST) begin
            h_next = '0;
            v_next = (v == V_LAST) ? '0 : v + 1'b1;
        end
    end

    always_comb begin
        raw             = IDLE;
        raw.hblank      = (h >= H_ACT_C);
        raw.vblank      = (v >= V_ACT_C);
        raw.de          = !raw.hblank && !raw.vblank;
        // vsync is decoded from v alone, so its edges fall on h == 0.
        raw.hsync       = (h >= H_SYNC_LO && h < H_SYNC_HI) ? HS_ON : ~HS_ON;
        raw.vsync       = (v >= V_SYNC_LO && v < V_SYNC_HI) ? VS_ON : ~VS_ON;
        raw.line_start  = (h == '0);
        raw.frame_start = (h == '0) && (v == '0);
`ifdef VTG_XY_OUT_EN
        raw.x           = h;
        raw.y           = v;
`endif
    end

    // Priority: rst, then resync (counters only, pipeline holds), then en.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values and the chain shifts by exactly one stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            h <= '0;
            v <= '0;
            // NOTE: every pipeline stage is reset, not only the counters,
            // so the outputs show idle levels on the cycle after reset.
            for (int i = 0; i < DELAY; i++) begin
                pipe[i] <= IDLE;
            end
        end else if (resync) begin
            h <= '0;
            v <= '0;
        end else if (en) begin
            h       <= h_next;
            v       <= v_next;
            pipe[0] <= raw;
            for (int i = 1; i < DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign de          = pipe[DELAY-1].de;
    assign hblank      = pipe[DELAY-1].hblank;
    assign vblank      = pipe[DELAY-1].vblank;
    assign hsync       = pipe[DELAY-1].hsync;
    assign vsync       = pipe[DELAY-1].vsync;
    assign line_start  = pipe[DELAY-1].line_start;
    assign frame_start = pipe[DELAY-1].frame_start;
`ifdef VTG_XY_OUT_EN
    assign pix_x       = pipe[DELAY-1].x;
    assign pix_y       = pipe[DELAY-1].y;
`endif

endmodule
